// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI controller, datapath and register block.
//   XFER_W   : transfer width in bits
//   EDGE_CNT : SCK edges produced per transfer (two per bit)
//   spi_state_e : controller FSM state encoding
package spi_pkg;

  localparam int XFER_W   = 8;
  localparam int EDGE_CNT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen -- SCK edge-spacing divider.
//   clk, rst  : system clock, synchronous active-high reset
//   en        : divider runs while high, held at zero otherwise
//   shift_en  : ticks in this window are real SCK edges and advance the phase
//   div       : period length minus 1 (latched copy of cfg_div)
//   tick      : last cycle of the current D-cycle period
//   leading   : the next SCK edge is a leading (odd-numbered) edge
module spi_clkgen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       shift_en,
  input  logic [7:0] div,
  output logic       tick,
  output logic       leading
);

  logic [7:0] cnt;
  logic       phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= (cnt == div) ? 8'd0 : cnt + 8'd1;
      if (tick && shift_en) phase <= ~phase;
    end
  end

  assign tick    = en && (cnt == div);
  assign leading = ~phase;

endmodule

// File: rtl/spi_ctrl.sv
// spi_ctrl -- single-byte SPI master with programmable divider, CPOL/CPHA,
// chip-select selection/hold and abort.
//   cfg_div/cfg_cpol/cfg_cpha/cfg_cs_sel/cfg_cs_hold : transfer setup, latched on start
//   start, abort   : 1-cycle requests
//   tx_data        : byte to send; rx_data : last received byte
//   busy, done     : FSM not idle / 1-cycle completion pulse
//   sck, mosi, miso, cs_n : SPI bus (cs_n active low, one bit per slave)
module spi_ctrl #(
  parameter  int NUM_CS = 4,
  localparam int SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cfg_div,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic [SEL_W-1:0]  cfg_cs_sel,
  input  logic              cfg_cs_hold,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        tx_data,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  import spi_pkg::*;

  localparam logic [3:0] LAST_EDGE = 4'(EDGE_CNT - 1);

  spi_state_e        state;
  logic [7:0]        div_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              hold_q;
  logic [XFER_W-1:0] tx_sr;
  logic [XFER_W-1:0] rx_sr;
  logic [3:0]        edge_cnt;
  logic              tick;
  logic              leading;
  logic              clk_en;
  logic              shift_en;

  assign clk_en   = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign shift_en = (state == ST_SHIFT);

  spi_clkgen u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_en),
    .shift_en (shift_en),
    .div      (div_q),
    .tick     (tick),
    .leading  (leading)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      hold_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort drops everything; a held CS is released too, even from IDLE.
        state    <= ST_IDLE;
        busy     <= 1'b0;
        cs_n     <= '1;
        edge_cnt <= '0;
        sck      <= (state == ST_IDLE) ? cfg_cpol : cpol_q;
      end else begin
        case (state)
          ST_IDLE: begin
            sck <= cfg_cpol;
            if (start) begin
              state    <= ST_SETUP;
              busy     <= 1'b1;
              div_q    <= cfg_div;
              cpol_q   <= cfg_cpol;
              cpha_q   <= cfg_cpha;
              hold_q   <= cfg_cs_hold;
              tx_sr    <= tx_data;
              rx_sr    <= '0;
              edge_cnt <= '0;
              // Full overwrite also releases any other slave left held.
              cs_n     <= ~(NUM_CS'(1) << cfg_cs_sel);
              if (!cfg_cpha) mosi <= tx_data[XFER_W-1];
            end
          end
          ST_SETUP: begin
            if (tick) state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (tick) begin
              sck      <= ~sck;
              edge_cnt <= edge_cnt + 4'd1;
              if (leading) begin
                if (cpha_q) begin
                  mosi  <= tx_sr[XFER_W-1];
                  tx_sr <= tx_sr << 1;
                end else begin
                  rx_sr <= {rx_sr[XFER_W-2:0], miso};
                end
              end else begin
                if (cpha_q) begin
                  rx_sr <= {rx_sr[XFER_W-2:0], miso};
                end else if (edge_cnt != LAST_EDGE) begin
                  // CPHA=0 pre-loaded bit7 in SETUP, so advance to the next bit.
                  mosi  <= tx_sr[XFER_W-2];
                  tx_sr <= tx_sr << 1;
                end
              end
              if (edge_cnt == LAST_EDGE) begin
                state    <= ST_HOLD;
                edge_cnt <= '0;
              end
            end
          end
          ST_HOLD: begin
            sck <= cpol_q;
            if (tick) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              rx_data <= rx_sr;
              if (!hold_q) cs_n <= '1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cs_n  <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ctrl.sv
// tb_spi_ctrl -- directed self-checking bench for spi_ctrl.
module tb_spi_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_div;
  logic       cfg_cpol;
  logic       cfg_cpha;
  logic [1:0] cfg_cs_sel;
  logic       cfg_cs_hold;
  logic       start;
  logic       abort;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       sck;
  logic       mosi;
  wire        miso;
  logic [3:0] cs_n;

  logic       loop_en  = 1'b1;
  logic       slave_en = 1'b0;
  logic       slave_bit = 1'b0;
  logic [7:0] slave_sr  = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : slave_bit;

  // CPOL=1/CPHA=1 slave: shifts out MSB first on each leading (falling) SCK edge.
  always @(negedge sck) begin
    if (slave_en) begin
      slave_bit = slave_sr[7];
      slave_sr  = {slave_sr[6:0], 1'b0};
    end
  end

  spi_ctrl #(.NUM_CS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_div     (cfg_div),
    .cfg_cpol    (cfg_cpol),
    .cfg_cpha    (cfg_cpha),
    .cfg_cs_sel  (cfg_cs_sel),
    .cfg_cs_hold (cfg_cs_hold),
    .start       (start),
    .abort       (abort),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .busy        (busy),
    .done        (done),
    .sck         (sck),
    .mosi        (mosi),
    .miso        (miso),
    .cs_n        (cs_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cs_n"}, cs_n, 4'b1111);
    check({tag, "_sck"},  sck,  1'b0);
    check({tag, "_mosi"}, mosi, 1'b0);
    check({tag, "_rx"},   rx_data, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // Starts a transfer at the current negedge (sampled at edge 0) and watches
  // cycles 1..18D+3. inj>0 also pulses start at cycle inj and in the DONE cycle.
  task automatic run_xfer(input logic [7:0] div, input logic cpol, input logic cpha,
                          input logic [1:0] sel, input logic hold, input logic [7:0] tx,
                          input logic [7:0] exp_rx, input int inj);
    int d, last, done_cnt, done_cyc, busy_err, cs_err, edges, last_edge, gap_err;
    logic prev_sck;
    logic [7:0] mosi_bits;
    logic [3:0] act_cs, exp_cs;
    d = int'(div) + 1;
    last = 18 * d + 1;
    act_cs = ~(4'b0001 << sel);
    done_cnt = 0; done_cyc = 0; busy_err = 0; cs_err = 0;
    edges = 0; last_edge = 0; gap_err = 0; mosi_bits = 8'h00;
    cfg_div = div; cfg_cpol = cpol; cfg_cpha = cpha;
    cfg_cs_sel = sel; cfg_cs_hold = hold; tx_data = tx; start = 1'b1;
    prev_sck = cpol;
    for (int cyc = 1; cyc <= last + 2; cyc++) begin
      @(negedge clk);
      start = (inj != 0) && (cyc == inj || cyc == last);
      if (cyc == 1) begin
        tx_data = ~tx;
        cfg_div = div ^ 8'h05;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy !== (cyc <= last)) busy_err++;
      exp_cs = (cyc < last || hold) ? act_cs : 4'b1111;
      if (cs_n !== exp_cs) cs_err++;
      if (sck !== prev_sck) begin
        edges++;
        if (last_edge != 0 && cyc - last_edge != d) gap_err++;
        last_edge = cyc;
        if (sck) mosi_bits = {mosi_bits[6:0], mosi};
      end
      prev_sck = sck;
    end
    start = 1'b0;
    check("done_cycle", done_cyc, last);
    check("done_count", done_cnt, 1);
    check("busy_window", busy_err, 0);
    check("cs_n_seq", cs_err, 0);
    check("sck_edges", edges, 16);
    check("sck_spacing", gap_err, 0);
    check("mosi_bits", mosi_bits, tx);
    check("rx_data", rx_data, exp_rx);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; cfg_div = 8'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
    cfg_cs_sel = 2'd0; cfg_cs_hold = 1'b0; start = 1'b0; abort = 1'b0; tx_data = 8'h00;

    // Reset, with start/abort asserted to show reset overrides them.
    repeat (2) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_reset_state("reset");
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    @(negedge clk);

    // Mode 0, div=0, loopback.
    run_xfer(8'd0, 1'b0, 1'b0, 2'd0, 1'b0, 8'hA5, 8'hA5, 0);
    check("m0_cs_after", cs_n, 4'b1111);

    // IDLE sck follows cfg_cpol with one cycle of latency.
    cfg_cpol = 1'b1;
    @(negedge clk);
    check("idle_sck_cpol1", sck, 1'b1);

    // Mode 3, div=3, slave returns 0xC3.
    loop_en = 1'b0; slave_en = 1'b1; slave_sr = 8'hC3;
    run_xfer(8'd3, 1'b1, 1'b1, 2'd0, 1'b0, 8'h3C, 8'hC3, 0);
    check("m3_sck_idle", sck, 1'b1);
    slave_en = 1'b0; loop_en = 1'b1;
    cfg_cpol = 1'b0;
    @(negedge clk);
    check("idle_sck_cpol0", sck, 1'b0);

    // CS hold across two transfers; second also gets start in SHIFT and DONE.
    run_xfer(8'd0, 1'b0, 1'b0, 2'd2, 1'b1, 8'h12, 8'h12, 0);
    run_xfer(8'd0, 1'b0, 1'b0, 2'd2, 1'b0, 8'h34, 8'h34, 5);
    check("hold_release", cs_n, 4'b1111);

    // Held CS on slave 2 is dropped when slave 1 is selected.
    run_xfer(8'd1, 1'b0, 1'b1, 2'd2, 1'b1, 8'h5A, 8'h5A, 0);
    run_xfer(8'd0, 1'b0, 1'b0, 2'd1, 1'b0, 8'h0F, 8'h0F, 0);

    // Abort in IDLE releases a held CS.
    run_xfer(8'd0, 1'b0, 1'b0, 2'd3, 1'b1, 8'h81, 8'h81, 0);
    check("held_cs3", cs_n, 4'b0111);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_cs", cs_n, 4'b1111);

    // Abort and start together in IDLE: abort wins.
    abort = 1'b1; start = 1'b1; cfg_cs_sel = 2'd0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 1'b0);
    check("abort_start_cs", cs_n, 4'b1111);

    // Abort during SHIFT at cycle 8.
    cfg_div = 8'd0; cfg_cs_sel = 2'd0; cfg_cs_hold = 1'b0; tx_data = 8'h77; start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 8) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_cs", cs_n, 4'b1111);
    check("abort_busy", busy, 1'b0);
    check("abort_sck", sck, 1'b0);
    done_seen = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", done_seen, 0);
    check("abort_rx_kept", rx_data, 8'h81);

    // Reset mid-SHIFT, then a normal transfer.
    tx_data = 8'h66; start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    run_xfer(8'd0, 1'b0, 1'b0, 2'd1, 1'b0, 8'hFF, 8'hFF, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
